// File: rtl/ysyx_25020037_axi_rd_arb_pkg.sv
// Shared definitions for the IFU/LSU AXI read arbiter.
//   arb_state_e : arbiter FSM encodings (IDLE/ADDR/DATA)
//   ARB_IFU/LSU : requester indices used as the grant value
//   *_W         : fixed AXI field widths
package ysyx_25020037_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic ARB_IFU = 1'b0;
  localparam logic ARB_LSU = 1'b1;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

endpackage

// File: rtl/ysyx_25020037_rr_pick2.sv
// Combinational 2-way round-robin pick.
//   req  : request vector, bit N = requester N
//   last : requester granted most recently
//   gnt  : chosen requester (only meaningful when |req)
module ysyx_25020037_rr_pick2
  import ysyx_25020037_axi_rd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  // On a tie the requester that did not go last wins; otherwise the lone requester.
  assign gnt = (req == 2'b11) ? ~last : (req[1] ? ARB_LSU : ARB_IFU);

endmodule

// File: rtl/ysyx_25020037_axi_rd_arb.sv
// Two-requester AXI4 read-channel arbiter sharing one read master port
// between the IFU (m0) and the LSU (m1). One burst outstanding at a time;
// the grant is held from AR accept until the rlast beat; round-robin fairness.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mN_ar*            : requester N read address channel
//   mN_r*             : requester N read data channel (data fields shared)
//   s_ar*, s_r*       : slave-side read address / data channels
//   busy              : arbiter not idle
//   proto_err         : sticky protocol violation flag, cleared only by rst
module ysyx_25020037_axi_rd_arb
  import ysyx_25020037_axi_rd_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  // requester 0 (IFU)
  input  logic               m0_arvalid,
  output logic               m0_arready,
  input  logic [ADDR_W-1:0]  m0_araddr,
  input  logic [ID_W-1:0]    m0_arid,
  input  logic [LEN_W-1:0]   m0_arlen,
  input  logic [SIZE_W-1:0]  m0_arsize,
  input  logic [BURST_W-1:0] m0_arburst,
  output logic               m0_rvalid,
  input  logic               m0_rready,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic [RESP_W-1:0]  m0_rresp,
  output logic               m0_rlast,
  output logic [ID_W-1:0]    m0_rid,
  // requester 1 (LSU)
  input  logic               m1_arvalid,
  output logic               m1_arready,
  input  logic [ADDR_W-1:0]  m1_araddr,
  input  logic [ID_W-1:0]    m1_arid,
  input  logic [LEN_W-1:0]   m1_arlen,
  input  logic [SIZE_W-1:0]  m1_arsize,
  input  logic [BURST_W-1:0] m1_arburst,
  output logic               m1_rvalid,
  input  logic               m1_rready,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic [RESP_W-1:0]  m1_rresp,
  output logic               m1_rlast,
  output logic [ID_W-1:0]    m1_rid,
  // slave port
  output logic               s_arvalid,
  input  logic               s_arready,
  output logic [ADDR_W-1:0]  s_araddr,
  output logic [ID_W-1:0]    s_arid,
  output logic [LEN_W-1:0]   s_arlen,
  output logic [SIZE_W-1:0]  s_arsize,
  output logic [BURST_W-1:0] s_arburst,
  input  logic               s_rvalid,
  output logic               s_rready,
  input  logic [DATA_W-1:0]  s_rdata,
  input  logic [RESP_W-1:0]  s_rresp,
  input  logic               s_rlast,
  input  logic [ID_W-1:0]    s_rid,
  // status
  output logic               busy,
  output logic               proto_err
);

  arb_state_e        state;
  logic              gnt;
  logic              last_gnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ID_W-1:0]   id_q;

  logic              pick;
  logic              in_addr;
  logic              in_data;
  logic              r_hs;

  // Granted requester's AR fields
  logic               g_arvalid;
  logic [ADDR_W-1:0]  g_araddr;
  logic [ID_W-1:0]    g_arid;
  logic [LEN_W-1:0]   g_arlen;
  logic [SIZE_W-1:0]  g_arsize;
  logic [BURST_W-1:0] g_arburst;
  logic               g_rready;

  ysyx_25020037_rr_pick2 u_pick (
    .req  ({m1_arvalid, m0_arvalid}),
    .last (last_gnt),
    .gnt  (pick)
  );

  assign in_addr = (state == ARB_ADDR);
  assign in_data = (state == ARB_DATA);

  // Request mux
  assign g_arvalid = (gnt == ARB_LSU) ? m1_arvalid : m0_arvalid;
  assign g_araddr  = (gnt == ARB_LSU) ? m1_araddr  : m0_araddr;
  assign g_arid    = (gnt == ARB_LSU) ? m1_arid    : m0_arid;
  assign g_arlen   = (gnt == ARB_LSU) ? m1_arlen   : m0_arlen;
  assign g_arsize  = (gnt == ARB_LSU) ? m1_arsize  : m0_arsize;
  assign g_arburst = (gnt == ARB_LSU) ? m1_arburst : m0_arburst;
  assign g_rready  = (gnt == ARB_LSU) ? m1_rready  : m0_rready;

  // Slave AR channel: only driven while in ADDR
  assign s_arvalid = in_addr & g_arvalid;
  assign s_araddr  = in_addr ? g_araddr  : '0;
  assign s_arid    = in_addr ? g_arid    : '0;
  assign s_arlen   = in_addr ? g_arlen   : '0;
  assign s_arsize  = in_addr ? g_arsize  : '0;
  assign s_arburst = in_addr ? g_arburst : '0;

  // Handshake signals steered to the granted requester only
  assign m0_arready = in_addr & (gnt == ARB_IFU) & s_arready;
  assign m1_arready = in_addr & (gnt == ARB_LSU) & s_arready;
  assign m0_rvalid  = in_data & (gnt == ARB_IFU) & s_rvalid;
  assign m1_rvalid  = in_data & (gnt == ARB_LSU) & s_rvalid;
  assign s_rready   = in_data & g_rready;
  assign r_hs       = in_data & s_rvalid & g_rready;

  // Read payload is shared; rvalid qualifies it
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;

  assign busy = (state != ARB_IDLE);

  // Arbiter FSM with beat checker
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt       <= ARB_IFU;
      last_gnt  <= ARB_LSU;
      beat_cnt  <= '0;
      len_q     <= '0;
      id_q      <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            gnt   <= pick;
            state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          // Withdrawing arvalid before accept is illegal; drop the grant
          if (!g_arvalid) begin
            proto_err <= 1'b1;
            state     <= ARB_IDLE;
          end else if (s_arready) begin
            len_q    <= g_arlen;
            id_q     <= g_arid;
            beat_cnt <= '0;
            state    <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            // rlast must coincide exactly with the final counted beat
            if ((s_rid != id_q) || (s_rlast != (beat_cnt == len_q)))
              proto_err <= 1'b1;
            if (s_rlast) begin
              last_gnt <= gnt;
              state    <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_arb.sv
module tb_ysyx_25020037_axi_rd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        busy, proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25020037_axi_rd_arb dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0;
    m0_arsize = 3'd2; m0_arburst = 2'd1; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0;
    m1_arsize = 3'd2; m1_arburst = 2'd1; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] id, input logic last);
    s_rvalid = 1; s_rdata = d; s_rid = id; s_rlast = last;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(proto_err), 0);
    chk("rst_s_arvalid", 32'(s_arvalid), 0);
    chk("rst_s_rready", 32'(s_rready), 0);
    chk("rst_m0_arready", 32'(m0_arready), 0);

    // ---------------- 1: m0 single beat
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; m0_arid = 4'd2; m0_arlen = 8'd0;
    s_arready = 1;
    #1 chk("t1_bubble", 32'(s_arvalid), 0);
    tick();
    chk("t1_s_arvalid", 32'(s_arvalid), 1);
    chk("t1_s_araddr", s_araddr, 32'h3000_0000);
    chk("t1_m0_arready", 32'(m0_arready), 1);
    chk("t1_m1_arready", 32'(m1_arready), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    beat(32'hDEAD_BEEF, 4'd2, 1);
    #1;
    chk("t1_s_arvalid_data", 32'(s_arvalid), 0);
    chk("t1_m0_rvalid", 32'(m0_rvalid), 1);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 0);
    chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t1_m0_rlast", 32'(m0_rlast), 1);
    chk("t1_s_rready", 32'(s_rready), 1);
    tick();
    idle_inputs();
    #1;
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_err", 32'(proto_err), 0);

    // ---------------- 2: simultaneous requests after reset
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h0000_1000; m0_arid = 4'd1;
    m1_arvalid = 1; m1_araddr = 32'h0000_2000; m1_arid = 4'd5;
    s_arready = 1;
    tick();
    #1;
    chk("t2_first_addr", s_araddr, 32'h0000_1000);
    chk("t2_m0_arready", 32'(m0_arready), 1);
    chk("t2_m1_arready", 32'(m1_arready), 0);
    tick();
    m0_arvalid = 0; m0_rready = 1; m1_rready = 1;
    beat(32'h1111_1111, 4'd1, 1);
    #1;
    chk("t2_m1_waits", 32'(s_arvalid), 0);
    chk("t2_m0_rvalid", 32'(m0_rvalid), 1);
    chk("t2_m1_rvalid", 32'(m1_rvalid), 0);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1 chk("t2_idle_between", 32'(busy), 0);
    tick();
    #1;
    chk("t2_second_addr", s_araddr, 32'h0000_2000);
    chk("t2_m1_arready2", 32'(m1_arready), 1);
    chk("t2_m0_arready2", 32'(m0_arready), 0);
    tick();
    m1_arvalid = 0;
    beat(32'h2222_2222, 4'd5, 1);
    m0_arvalid = 1; m0_araddr = 32'h0000_3000; m0_arid = 4'd1;
    m1_arvalid = 1; m1_araddr = 32'h0000_4000;
    #1;
    chk("t2_m1_rvalid2", 32'(m1_rvalid), 1);
    chk("t2_m0_rvalid2", 32'(m0_rvalid), 0);
    tick();
    s_rvalid = 0; s_rlast = 0;
    tick();
    #1 chk("t2_tie_to_m0", s_araddr, 32'h0000_3000);
    tick();
    m0_arvalid = 0; m1_arvalid = 0;
    beat(32'h3333_3333, 4'd1, 1);
    tick();
    idle_inputs();
    #1 chk("t2_err", 32'(proto_err), 0);

    // ---------------- 3: m1 4-beat burst with rready toggling
    m1_arvalid = 1; m1_araddr = 32'hA000_0000; m1_arid = 4'd7; m1_arlen = 8'd3;
    s_arready = 1;
    tick();
    #1 chk("t3_addr", s_araddr, 32'hA000_0000);
    chk("t3_arlen", 32'(s_arlen), 3);
    tick();
    m1_arvalid = 0; s_arready = 0;
    beat(32'hB000_0000, 4'd7, 0); m1_rready = 0;
    #1;
    chk("t3_stall_rready", 32'(s_rready), 0);
    chk("t3_m1_rvalid", 32'(m1_rvalid), 1);
    chk("t3_m0_rvalid", 32'(m0_rvalid), 0);
    tick();
    m1_rready = 1;
    #1 chk("t3_b0", m1_rdata, 32'hB000_0000);
    tick();
    beat(32'hB000_0001, 4'd7, 0); m1_rready = 0;
    tick();
    m1_rready = 1;
    #1 chk("t3_b1", m1_rdata, 32'hB000_0001);
    tick();
    beat(32'hB000_0002, 4'd7, 0);
    tick();
    beat(32'hB000_0003, 4'd7, 1);
    #1;
    chk("t3_b3", m1_rdata, 32'hB000_0003);
    chk("t3_rlast", 32'(m1_rlast), 1);
    chk("t3_busy_last", 32'(busy), 1);
    tick();
    idle_inputs();
    #1;
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_err", 32'(proto_err), 0);

    // ---------------- 4a: early rlast
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'd3; m0_arlen = 8'd3;
    s_arready = 1;
    tick();
    tick();
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    beat(32'hC000_0000, 4'd3, 0);
    tick();
    #1 chk("t4_err_before", 32'(proto_err), 0);
    beat(32'hC000_0001, 4'd3, 1);
    tick();
    idle_inputs();
    #1;
    chk("t4_early_rlast_err", 32'(proto_err), 1);
    chk("t4_idle", 32'(busy), 0);

    // ---------------- 4b: rid mismatch alone
    do_reset();
    chk("t4b_err_clr", 32'(proto_err), 0);
    m0_arvalid = 1; m0_arid = 4'd3; m0_arlen = 8'd0; s_arready = 1;
    tick();
    tick();
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    beat(32'hC000_0002, 4'd4, 1);
    tick();
    idle_inputs();
    #1 chk("t4_rid_err", 32'(proto_err), 1);

    // ---------------- 5: reset mid-burst
    do_reset();
    m1_arvalid = 1; m1_arid = 4'd6; m1_arlen = 8'd3; s_arready = 1;
    tick();
    tick();
    m1_arvalid = 0; s_arready = 0; m1_rready = 1;
    beat(32'hD000_0000, 4'd6, 0);
    tick();
    beat(32'hD000_0001, 4'd6, 0);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_s_rready", 32'(s_rready), 0);
    chk("t5_m1_rvalid", 32'(m1_rvalid), 0);
    chk("t5_s_arvalid", 32'(s_arvalid), 0);
    chk("t5_m1_arready", 32'(m1_arready), 0);
    idle_inputs();
    m0_arvalid = 1; m0_araddr = 32'h3000_0040; m0_arid = 4'd1; s_arready = 1;
    tick();
    #1;
    chk("t5_regrant_addr", s_araddr, 32'h3000_0040);
    chk("t5_regrant_arready", 32'(m0_arready), 1);
    tick();
    m0_arvalid = 0; m0_rready = 1; s_arready = 0;
    beat(32'hD000_0002, 4'd1, 1);
    tick();
    idle_inputs();
    #1 chk("t5_err", 32'(proto_err), 0);

    // ---------------- 6: granted arvalid withdrawn in ADDR
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h3000_0080;
    m1_arvalid = 1; m1_araddr = 32'hA000_0100;
    s_arready = 0;
    tick();
    #1;
    chk("t6_addr_m0", s_araddr, 32'h3000_0080);
    chk("t6_no_arready", 32'(m0_arready), 0);
    m0_arvalid = 0;
    #1 chk("t6_arvalid_follows", 32'(s_arvalid), 0);
    tick();
    #1;
    chk("t6_err", 32'(proto_err), 1);
    chk("t6_idle", 32'(busy), 0);
    tick();
    #1;
    chk("t6_m1_granted", s_araddr, 32'hA000_0100);
    chk("t6_m1_arvalid", 32'(s_arvalid), 1);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
